// File: rtl/spi_cfg_master.sv
// spi_cfg_master: round-robin arbiter for two write requesters driving 16-bit SPI mode-0 config frames
module spi_cfg_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [6:0] b_addr,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       spi_sclk,
    output logic       spi_copi,
    output logic       spi_cs,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       grant_b
);
    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;
    localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LD = 8'(CS_GAP - 1);
    state_t      state;
    logic [14:0] frame;
    logic [3:0]  bit_cnt;
    logic [7:0]  half_cnt;
    logic        a_win;
    logic        b_win;
    logic        accept;
    logic [6:0]  sel_addr;
    logic [7:0]  sel_data;
    always_comb begin
        a_win    = a_valid && (!b_valid || grant_b);
        b_win    = b_valid && !a_win;
        a_ready  = a_win && state == IDLE;
        b_ready  = b_win && state == IDLE;
        accept   = a_ready || b_ready;
        sel_addr = a_ready ? a_addr : b_addr;
        sel_data = a_ready ? a_data : b_data;
    end
    // frame holds the bits still to be sent after the current one; the leading write bit is always 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            frame    <= '0;
            bit_cnt  <= '0;
            half_cnt <= '0;
            spi_sclk <= 1'b0;
            spi_copi <= 1'b0;
            spi_cs   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            grant_b  <= 1'b1;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    grant_b <= b_ready;
                    if (sel_addr > 7'h04) err <= 1'b1;
                    else begin
                        frame    <= {sel_addr, sel_data};
                        spi_copi <= 1'b1;
                        spi_cs   <= 1'b0;
                        busy     <= 1'b1;
                        bit_cnt  <= 4'd15;
                        half_cnt <= DIV_LD;
                        state    <= SHIFT_LO;
                    end
                end
                SHIFT_LO: if (half_cnt == 8'd0) begin
                    spi_sclk <= 1'b1;
                    half_cnt <= DIV_LD;
                    state    <= SHIFT_HI;
                end else half_cnt <= half_cnt - 8'd1;
                SHIFT_HI: if (half_cnt == 8'd0) begin
                    spi_sclk <= 1'b0;
                    half_cnt <= DIV_LD;
                    if (bit_cnt == 4'd0) state <= HOLD;
                    else begin
                        bit_cnt  <= bit_cnt - 4'd1;
                        spi_copi <= frame[14];
                        frame    <= {frame[13:0], 1'b0};
                        state    <= SHIFT_LO;
                    end
                end else half_cnt <= half_cnt - 8'd1;
                HOLD: if (half_cnt == 8'd0) begin
                    spi_cs   <= 1'b1;
                    spi_copi <= 1'b0;
                    done     <= 1'b1;
                    half_cnt <= GAP_LD;
                    state    <= GAP;
                end else half_cnt <= half_cnt - 8'd1;
                GAP: if (half_cnt == 8'd0) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else half_cnt <= half_cnt - 8'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
